// File: rtl/booth_sched_pkg.sv
// rtl/booth_sched_pkg.sv - shared types and defaults for the Booth multiplier scheduler
package booth_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT,
    RESP
  } state_e;

  localparam int W_DEF       = 8;
  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 64;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/booth_mult_scheduler_rr_arbiter.sv
// rtl/booth_mult_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search starts after last grant
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    // Visit last+1 .. last+NREQ so the most recent winner is checked last
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/booth_mult_scheduler.sv
// rtl/booth_mult_scheduler.sv - arbitrates requesters onto one sequential Booth multiplier and returns tagged products
module booth_mult_scheduler
  import booth_sched_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*W-1:0]           req_a,
  input  logic [NREQ*W-1:0]           req_b,
  output logic [NREQ-1:0]             req_ready,
  output logic                        mul_start,
  output logic [W-1:0]                mul_a,
  output logic [W-1:0]                mul_b,
  input  logic                        mul_done,
  input  logic [2*W-1:0]              mul_product,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [id_width(NREQ)-1:0]   resp_id,
  output logic [2*W-1:0]              resp_product,
  output logic                        resp_err
);

  localparam int IW = id_width(NREQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  state_e         state_q, state_d;
  logic [IW-1:0]  last_q, last_d;
  logic [IW-1:0]  id_q, id_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic           err_q, err_d;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*W +: W];
    assign b_arr[i] = req_b[i*W +: W];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_valid (req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = ISSUE;
          last_d  = grant_idx;
          id_d    = grant_idx;
          a_d     = a_arr[grant_idx];
          b_d     = b_arr[grant_idx];
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = SETTLE;
      end
      // A done left over from the previous operation may still be high here
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + CW'(1);
        if (mul_done) begin
          state_d = RESP;
          prod_d  = mul_product;
          err_d   = 1'b0;
        end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
          state_d = RESP;
          prod_d  = '0;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IW'(NREQ - 1);
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  assign req_ready    = (state_q == IDLE) ? grant : '0;
  assign mul_start    = (state_q == ISSUE);
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign resp_valid   = (state_q == RESP);
  assign resp_id      = id_q;
  assign resp_product = prod_q;
  assign resp_err     = err_q;

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// tb/tb_booth_mult_scheduler.sv - directed self-checking bench for booth_mult_scheduler
module tb_booth_mult_scheduler;
  localparam int W       = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int IW      = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              mul_start, mul_done;
  logic [W-1:0]      mul_a, mul_b;
  logic [2*W-1:0]    mul_product, resp_product;
  logic              resp_valid, resp_ready, resp_err;
  logic [IW-1:0]     resp_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_mult_scheduler #(.W(W), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_done     (mul_done),
    .mul_product  (mul_product),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .resp_err     (resp_err)
  );

  // Multiplier model: done falls one edge after start and rises mdelay edges after start
  int             mdelay = 1;
  bit             mhang  = 1'b0;
  logic           mdone  = 1'b0;
  logic           mclr   = 1'b0;
  logic [2*W-1:0] mprod  = '0;
  logic [2*W-1:0] mnext  = '0;
  int             mcnt   = 0;

  assign mul_done    = mdone;
  assign mul_product = mprod;

  always @(posedge clk) begin
    if (mul_start) begin
      mnext <= $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
      mcnt  <= mdelay;
      mclr  <= 1'b1;
    end else begin
      mclr <= 1'b0;
      if (mclr) mdone <= 1'b0;
      if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && !mhang) begin
          mdone <= 1'b1;
          mprod <= mnext;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_req_ready"}, req_ready, 0);
    check({name, "_mul_start"}, mul_start, 0);
    check({name, "_mul_a"}, mul_a, 0);
    check({name, "_mul_b"}, mul_b, 0);
    check({name, "_resp_valid"}, resp_valid, 0);
    check({name, "_resp_id"}, resp_id, 0);
    check({name, "_resp_product"}, resp_product, 0);
    check({name, "_resp_err"}, resp_err, 0);
  endtask

  // Starts from an IDLE cycle, returns at the negedge where resp_valid is first seen
  task automatic do_txn(input logic [NREQ-1:0] mask, input int rid, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int dly, input bit hang,
                        input logic [2*W-1:0] exp_p, input bit exp_e);
    int lat, starts, m;
    mdelay = dly;
    mhang  = hang;
    @(negedge clk);
    req_valid = mask;
    req_a[rid*W +: W] = a;
    req_b[rid*W +: W] = b;
    #1;
    check("grant", req_ready, 1 << rid);
    @(negedge clk);
    req_valid = '0;
    check("issue_start", mul_start, 1);
    check("issue_ready", req_ready, 0);
    check("mul_a", mul_a, a);
    check("mul_b", mul_b, b);
    lat = 1;
    starts = 0;
    while (!resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if (mul_start) starts++;
    end
    m = hang ? TIMEOUT : dly;
    check("latency", lat, 3 + m);
    check("extra_start", starts, 0);
    check("resp_id", resp_id, rid);
    check("resp_product", resp_product, exp_p);
    check("resp_err", resp_err, exp_e);
  endtask

  typedef struct {
    int             rid;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    int             dly;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs [6];
  int   gq [8];
  int   gcyc [8];
  int   rq [8];
  int   ng, nr, cyc;
  bit   stable;

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    vecs[0] = '{0, 8'hFD, 8'h05, 1, 16'hFFF1};
    vecs[1] = '{0, 8'h80, 8'h80, 4, 16'h4000};
    vecs[2] = '{1, 8'h7F, 8'h80, 2, 16'hC080};
    vecs[3] = '{3, 8'h07, 8'h06, 7, 16'h002A};
    vecs[4] = '{2, 8'hFF, 8'hFF, 1, 16'h0001};
    vecs[5] = '{1, 8'h00, 8'h9C, 3, 16'h0000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    foreach (vecs[i])
      do_txn(4'(1 << vecs[i].rid), vecs[i].rid, vecs[i].a, vecs[i].b, vecs[i].dly, 1'b0, vecs[i].p, 1'b0);

    // Round-robin with all requesters valid, starting fresh from reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdelay = 1; mhang = 1'b0;
    req_a = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b = {8'd2, 8'd2, 8'd2, 8'd2};
    req_valid = 4'hF;
    ng = 0; nr = 0; cyc = 0;
    while (nr < 6 && cyc < 200) begin
      #1;
      if (|req_ready && ng < 8) begin
        for (int j = 0; j < NREQ; j++) if (req_ready[j]) gq[ng] = j;
        gcyc[ng] = cyc;
        ng++;
      end
      if (resp_valid && nr < 8) begin
        rq[nr] = resp_id;
        nr++;
      end
      cyc++;
      if (nr < 6) @(negedge clk);
    end
    req_valid = '0;
    check("rr_resp_count", nr, 6);
    check("rr_grant_count", ng, 6);
    for (int i = 0; i < 6; i++) begin
      check("rr_grant_order", gq[i], i % NREQ);
      check("rr_resp_id", rq[i], i % NREQ);
    end
    check("rr_spacing", gcyc[1] - gcyc[0], 5);

    // Backpressure: response held for 10 cycles while requester 0 waits
    @(negedge clk);
    resp_ready = 1'b0; mdelay = 2;
    req_valid = 4'b0100;
    req_a[2*W +: W] = 8'd5; req_b[2*W +: W] = 8'hF9;
    #1;
    check("bp_grant", req_ready, 4'b0100);
    cyc = 0;
    while (!resp_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req_valid = 4'b0001;
        req_a[0 +: W] = 8'd9; req_b[0 +: W] = 8'd9;
      end
    end
    check("bp_product", resp_product, 16'hFFDD);
    check("bp_id", resp_id, 2);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!resp_valid || resp_product !== 16'hFFDD || resp_id !== 2'd2 || resp_err !== 1'b0 || req_ready !== 4'b0)
        stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_next_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    cyc = 0;
    while (!resp_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_next_product", resp_product, 16'h0051);
    check("bp_next_id", resp_id, 0);

    // Timeout then recovery
    do_txn(4'b0010, 1, 8'h11, 8'h22, 1, 1'b1, 16'h0000, 1'b1);
    do_txn(4'b1000, 3, 8'hF6, 8'h0C, 2, 1'b0, 16'hFF88, 1'b0);

    // Reset during WAIT; stale done later high, arbitration pointer restarts
    @(negedge clk);
    mdelay = 20; mhang = 1'b0;
    req_valid = 4'b0010;
    req_a[1*W +: W] = 8'h0B; req_b[1*W +: W] = 8'h0D;
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    stable = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (resp_valid || mul_start) stable = 1'b0;
    end
    check("midrst_quiet", stable, 1);
    do_txn(4'b0101, 0, 8'hFE, 8'hFD, 3, 1'b0, 16'h0006, 1'b0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/booth_mult_scheduler.md
# booth_mult_scheduler

Shares one sequential Booth multiplier between `NREQ` independent requesters. Arbitrates round-robin and latches the winner's operands. Sequences the multiplier through start/done, then returns the signed product with the requester's ID on a single valid/ready response port. Sits between the client logic and the Booth datapath+controlpath pair. It is the only agent allowed to start the multiplier.

## Interface
- `W`, 8: operand width in bits (signed, two's complement); the product is `2W` bits.
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 64: maximum cycles to wait for `mul_done` before aborting.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request.
- `req_a`  in  NREQ*W  multiplicands, flattened; requester i occupies bits [i*W +: W].
- `req_b`  in  NREQ*W  multipliers, same packing.
- `req_ready`  out  NREQ  one-hot acceptance pulse.
- `mul_start`  out  1  one-cycle pulse that loads operands into the multiplier.
- `mul_a`, `mul_b`  out  W  operands to the multiplier; held stable from ISSUE until RESP exits.
- `mul_done`  in  1  multiplier done; a level, held until the next `mul_start`.
- `mul_product`  in  2W  multiplier result; valid while `mul_done` is high.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_id`  out  clog2(NREQ)  index of the served requester.
- `resp_product`  out  2W  registered product.
- `resp_err`  out  1  high when the response is a timeout abort.

## Operation
- FSM states:
  - IDLE → ISSUE when any `req_valid` is high. `req_ready[g]` = 1 for the winner g in this same cycle. The operands and g are latched on this edge.
  - ISSUE → SETTLE. `mul_start` = 1 for exactly this cycle.
  - SETTLE → WAIT. `mul_done` is ignored here, because a stale done from the previous operation may still be high.
  - WAIT → RESP when `mul_done` = 1. `mul_product` is captured into `resp_product` and `resp_err` = 0.
  - WAIT → RESP when the timeout counter reaches `TIMEOUT`. Then `resp_product` = 0 and `resp_err` = 1.
  - RESP: `resp_valid` = 1. RESP → IDLE on `resp_valid && resp_ready`.
- Round-robin:
  - A pointer `last` holds the most recently granted index. The search starts at `last+1` and wraps modulo `NREQ`.
  - `last` updates only on a grant. A requester that deasserts `req_valid` before being granted loses no fairness.
- Only one operation is in flight; `req_ready` is 0 in every state except IDLE.
- A response in RESP blocks new grants. Backpressure on `resp_ready` therefore stalls all requesters.
- The timeout counter clears in ISSUE and increments each WAIT cycle. It saturates at `TIMEOUT` and is never wider than clog2(TIMEOUT)+1 bits.
- Requesters must hold `req_a`/`req_b` stable while `req_valid` is high. Data is sampled only on the grant cycle.

## Timing
- Reset (synchronous, takes effect at the edge where `rst` = 1, overriding all other activity including mid-operation):
  - state = IDLE, `last` = NREQ-1 (requester 0 wins first), timeout counter = 0.
  - Every output is 0: `req_ready`, `mul_start`, `mul_a`, `mul_b`, `resp_valid`, `resp_id`, `resp_product`, `resp_err`.
  - A multiplier operation already in progress is abandoned; its later `mul_done` is discarded by the SETTLE rule.
- Latency from the grant cycle to the first `resp_valid` = 3 + M cycles. M is the number of WAIT cycles until `mul_done`; M ≥ 1.
- Minimum spacing between consecutive grants is 5 cycles, with `resp_ready` tied high and M = 1.
- The IDLE decision is combinational on `req_valid`, so a request arriving while in IDLE is granted in the same cycle.
- `resp_*` outputs are registered and stay constant while `resp_valid && !resp_ready`.

## Structure
- Package `booth_sched_pkg`:
  - state enum (IDLE, ISSUE, SETTLE, WAIT, RESP);
  - default `W`, `NREQ`, `TIMEOUT` constants;
  - an ID-width function.
- Sub-module `rr_arbiter`: combinational. Takes the `req_valid` vector and `last`, and returns a one-hot grant and its encoded index.
- Everything else (FSM, operand/ID latches, timeout counter, response register) lives in the top module.

## Test plan
- Single requester, W=8: requester 0 sends a=-3, b=5 → one `req_ready[0]` pulse, one `mul_start` pulse, then `resp_product` = 16'hFFF1 with `resp_id` = 0 and `resp_err` = 0.
- Extreme operands: a=-128, b=-128 → 16'h4000. Also a=127, b=-128 → 16'hC080.
- All 4 requesters continuously valid → grant order 0,1,2,3,0,1, and each `resp_id` matches its grant.
- Backpressure: hold `resp_ready` low for 10 cycles in RESP → `resp_valid` and the response data stay constant, and `req_ready` stays 0. The next grant comes one cycle after the `resp_ready` handshake.
- Timeout: the multiplier model never asserts `mul_done` → exactly TIMEOUT WAIT cycles, then `resp_err` = 1 with `resp_product` = 0. The scheduler then recovers and serves the next request.
- Reset mid-operation: assert `rst` during WAIT → all outputs 0 at the next edge. The stale `mul_done` is ignored, and the next grant goes to requester 0.
